note_sequencer: RTL and testbench

Song-playback sequencer feeding the LED/key-indicator stage. Reads 7-bit note codes from a song ROM and presents the current note (`note_led`) and upcoming note (`next_note_led`) as 8-bit one-hot LED patterns. Raises `isEnd` when the song finishes. Steps on a beat timer in AUTOPLAY/CHALLENGE and on the player pressing the matching key in STUDY.

---
 rtl/note_sequencer_if.sv | 28 ++
 rtl/note_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_note_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Bus bundle between the song sequencer and its neighbours: the mode/control
// inputs, the song ROM port, and the LED/buzzer outputs.
// "master" is the controller/ROM side; "slave" is the sequencer.
interface note_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic [2:0]        state;
    logic              start;
    logic [ADDR_W-1:0] song_len;
    logic [6:0]        key_in;
    logic [ADDR_W-1:0] rom_addr;
    logic [6:0]        rom_data;
    logic [6:0]        note_code;
    logic [7:0]        note_led;
    logic [7:0]        next_note_led;
    logic              isEnd;
    logic              busy;

    modport master (
        output state, start, song_len, key_in, rom_data,
        input  rom_addr, note_code, note_led, next_note_led, isEnd, busy
    );

    modport slave (
        input  state, start, song_len, key_in, rom_data,
        output rom_addr, note_code, note_led, next_note_led, isEnd, busy
    );
endinterface

// File: rtl/note_sequencer.sv
// Song-playback sequencer. Walks a song ROM of 7-bit note codes and shows
// the current and upcoming note as one-hot LED patterns. Notes advance on a
// beat timer in AUTOPLAY/CHALLENGE, and on the matching key press in STUDY.
// start and key_in are registered before use, so a start sampled at edge k
// drives rom_addr=0 after edge k+1 and a key sampled at edge j ends the note
// at edge j+1.
// Optional feature: define NOTE_SEQ_LOOP_EN to make the song wrap back to
// note 0 after the final gap (isEnd then pulses for one cycle per wrap).
module note_sequencer #(
    parameter int BEAT_CYCLES = 16000,
    parameter int GAP_CYCLES  = 2800,
    parameter int ADDR_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    note_sequencer_if.slave  bus
);

    // Counter is shared by note duration and gap, so size it for the larger.
    localparam int MAX_CNT = (4 * BEAT_CYCLES > GAP_CYCLES) ? 4 * BEAT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

    localparam logic [2:0] MODE_AUTOPLAY  = 3'b010;
    localparam logic [2:0] MODE_STUDY     = 3'b001;
    localparam logic [2:0] MODE_CHALLENGE = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F_CUR = 3'd1,
        F_NXT = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } fsm_e;

    fsm_e              state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        cur_q, cur_d;
    logic [6:0]        nxt_q, nxt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q;
    logic              start_q;
    logic [6:0]        key_q;

    logic [7:0]        note_led_q, note_led_d;
    logic [7:0]        next_led_q, next_led_d;
    logic [6:0]        code_q, code_d;
    logic              is_end_q, is_end_d;
    logic              busy_q, busy_d;

    logic              active;
    logic              study;
    logic              has_next;
    logic              wrap;

    // One-hot LED pattern for a note code; bit7 flags the high octave.
    function automatic logic [7:0] led_of(input logic [6:0] code);
        logic [7:0] led;
        led = 8'h00;
        if (code[6:4] != 3'd0) begin
            led[code[6:4] - 3'd1] = 1'b1;
            led[7]                = (code[3:2] == 2'b11);
        end
        return led;
    endfunction

    // Note duration in clock cycles from the two length bits.
    function automatic logic [CNT_W-1:0] dur_of(input logic [1:0] len);
        logic [CNT_W-1:0] d;
        case (len)
            2'b00:   d = CNT_W'(BEAT_CYCLES);
            2'b01:   d = CNT_W'(2 * BEAT_CYCLES);
            2'b10:   d = CNT_W'(BEAT_CYCLES / 2);
            default: d = CNT_W'(4 * BEAT_CYCLES);
        endcase
        return d;
    endfunction

    assign active = (bus.state == MODE_AUTOPLAY) || (bus.state == MODE_STUDY) ||
                    (bus.state == MODE_CHALLENGE);
    assign study  = (bus.state == MODE_STUDY);

    // True when the note after idx exists in the song.
    assign has_next = ({1'b0, idx_q} + (ADDR_W + 1)'(1)) < {1'b0, len_q};

    // Next-state and next-output logic; outputs are derived from the next
    // state so they leave the flops aligned with the state they describe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;

        if (!active) begin
            // Abort has priority over everything, including a pending start.
            state_d = IDLE;
            idx_d   = '0;
            addr_d  = '0;
            cur_d   = '0;
            nxt_d   = '0;
            cnt_d   = '0;
        end else if (start_q) begin
            idx_d   = '0;
            addr_d  = '0;
            cur_d   = '0;
            nxt_d   = '0;
            cnt_d   = '0;
            state_d = (len_q == '0) ? DONE : F_CUR;
        end else begin
            case (state_q)
                IDLE: begin
                end
                F_CUR: begin
                    cur_d   = bus.rom_data;
                    addr_d  = idx_q + ADDR_W'(1);
                    state_d = F_NXT;
                end
                F_NXT: begin
                    nxt_d   = has_next ? bus.rom_data : 7'd0;
                    cnt_d   = dur_of(cur_q[1:0]);
                    state_d = PLAY;
                end
                PLAY: begin
                    if (study && (cur_q[6:4] != 3'd0)) begin
                        // Untimed: wait for the key matching this pitch.
                        if (key_q[cur_q[6:4] - 3'd1]) begin
                            state_d = GAP;
                            cnt_d   = GAP_LOAD;
                        end
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q <= CNT_ONE) begin
                        if (!has_next) begin
`ifdef NOTE_SEQ_LOOP_EN
                            state_d = F_CUR;
                            idx_d   = '0;
                            addr_d  = '0;
                            wrap    = 1'b1;
`else
                            state_d = DONE;
`endif
                        end else begin
                            // cur is already known; only the new next note is fetched.
                            cur_d   = nxt_q;
                            idx_d   = idx_q + ADDR_W'(1);
                            addr_d  = idx_q + ADDR_W'(2);
                            state_d = F_NXT;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end

        note_led_d = (state_d == PLAY) ? led_of(cur_d) : 8'h00;
        code_d     = (state_d == PLAY) ? cur_d : 7'd0;
        next_led_d = ((state_d == PLAY) || (state_d == GAP)) ? led_of(nxt_d) : 8'h00;
        busy_d     = (state_d != IDLE) && (state_d != DONE);
        is_end_d   = (state_d == DONE) || wrap;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            cur_q      <= '0;
            nxt_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            start_q    <= 1'b0;
            key_q      <= '0;
            note_led_q <= '0;
            next_led_q <= '0;
            code_q     <= '0;
            is_end_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            cnt_q      <= cnt_d;
            if (bus.start) begin
                len_q <= bus.song_len;
            end
            start_q    <= bus.start && active;
            key_q      <= bus.key_in;
            note_led_q <= note_led_d;
            next_led_q <= next_led_d;
            code_q     <= code_d;
            is_end_q   <= is_end_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rom_addr      = addr_q;
    assign bus.note_code     = code_q;
    assign bus.note_led      = note_led_q;
    assign bus.next_note_led = next_led_q;
    assign bus.isEnd         = is_end_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random timed songs,
// each compared cycle by cycle against a trace built from the note rules.
module tb_note_sequencer;

    localparam int BEAT = 8;
    localparam int GAPC = 2;
    localparam int AW   = 9;

    localparam logic [2:0] AUTO  = 3'b010;
    localparam logic [2:0] STUDY = 3'b001;
    localparam logic [2:0] CHAL  = 3'b101;

    typedef struct packed {
        logic [7:0] led;
        logic [7:0] nled;
        logic [6:0] code;
        logic       is_end;
        logic       busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(AW)) bus ();

    note_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAPC),
        .ADDR_W     (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [6:0] rom [0:(1<<AW)-1];
    assign bus.rom_data = rom[bus.rom_addr];

    int   checks = 0;
    int   passed = 0;
    int   n01    = 0;
    int   n84    = 0;
    obs_t expq[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample_obs();
        obs_t o;
        o.led    = bus.note_led;
        o.nled   = bus.next_note_led;
        o.code   = bus.note_code;
        o.is_end = bus.isEnd;
        o.busy   = bus.busy;
        return o;
    endfunction

    // Reference LED pattern: pitch p lights bit p-1, high octave adds bit7.
    function automatic logic [7:0] ref_led(input logic [6:0] c);
        logic [7:0] r;
        int p;
        p = int'(c[6:4]);
        r = 8'h00;
        if (p != 0) begin
            r = 8'h01 << (p - 1);
            if (c[3:2] == 2'b11) r = r | 8'h80;
        end
        return r;
    endfunction

    function automatic int ref_dur(input logic [6:0] c);
        case (c[1:0])
            2'b00:   return BEAT;
            2'b01:   return 2 * BEAT;
            2'b10:   return BEAT / 2;
            default: return 4 * BEAT;
        endcase
    endfunction

    function automatic obs_t mk(input logic [7:0] l, input logic [7:0] n, input logic [6:0] c,
                                input logic e, input logic b);
        obs_t o;
        o.led = l; o.nled = n; o.code = c; o.is_end = e; o.busy = b;
        return o;
    endfunction

    // Expected per-cycle outputs for a timed song, starting with the sample
    // right after the edge that captured start.
    task automatic build_trace(input int len);
        logic [6:0] nx;
        expq.delete();
        expq.push_back(mk(8'h00, 8'h00, 7'd0, 1'b0, 1'b0));
        if (len == 0) begin
            repeat (3) expq.push_back(mk(8'h00, 8'h00, 7'd0, 1'b1, 1'b0));
            return;
        end
        expq.push_back(mk(8'h00, 8'h00, 7'd0, 1'b0, 1'b1));
        for (int i = 0; i < len; i++) begin
            nx = (i + 1 < len) ? rom[i + 1] : 7'd0;
            expq.push_back(mk(8'h00, 8'h00, 7'd0, 1'b0, 1'b1));
            repeat (ref_dur(rom[i])) expq.push_back(mk(ref_led(rom[i]), ref_led(nx), rom[i], 1'b0, 1'b1));
            repeat (GAPC) expq.push_back(mk(8'h00, ref_led(nx), 7'd0, 1'b0, 1'b1));
        end
`ifdef NOTE_SEQ_LOOP_EN
        nx = (len > 1) ? rom[1] : 7'd0;
        expq.push_back(mk(8'h00, 8'h00, 7'd0, 1'b1, 1'b1));
        expq.push_back(mk(8'h00, 8'h00, 7'd0, 1'b0, 1'b1));
        repeat (ref_dur(rom[0])) expq.push_back(mk(ref_led(rom[0]), ref_led(nx), rom[0], 1'b0, 1'b1));
`else
        repeat (3) expq.push_back(mk(8'h00, 8'h00, 7'd0, 1'b1, 1'b0));
`endif
    endtask

    task automatic start_song(input int len);
        build_trace(len);
        bus.song_len = AW'(len);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic run_trace(input string tag, input bit skip_first);
        obs_t o;
        n01 = 0;
        n84 = 0;
        foreach (expq[i]) begin
            if (i > 0) step();
            o = sample_obs();
            if (o.led == 8'h01) n01++;
            if (o.led == 8'h84) n84++;
            if (!(skip_first && i == 0))
                check($sformatf("%s_c%0d", tag, i), 32'(o), 32'(expq[i]));
        end
        $display("trace %s: %0d cycles compared", tag, expq.size());
    endtask

    task automatic go_idle();
        bus.state = 3'b000;
        step();
        check("idle_outputs", 32'(sample_obs()), 32'(0));
    endtask

    initial begin
        int len;
        logic [2:0] mode;
        for (int a = 0; a < (1 << AW); a++) rom[a] = 7'd0;
        bus.state    = 3'b000;
        bus.start    = 1'b0;
        bus.song_len = '0;
        bus.key_in   = 7'd0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(sample_obs()), 32'(0));
        check("reset_rom_addr", 32'(bus.rom_addr), 32'(0));
        rst = 1'b0;
        step();
        $display("reset: outputs checked");

        // Two-note example song in AUTOPLAY
        rom[0] = 7'b001_10_00;
        rom[1] = 7'b011_11_01;
        bus.state = AUTO;
        start_song(2);
        run_trace("example", 1'b0);
`ifdef NOTE_SEQ_LOOP_EN
        check("example_note0_cycles", 32'(n01), 32'(16));
`else
        check("example_note0_cycles", 32'(n01), 32'(8));
`endif
        check("example_note1_cycles", 32'(n84), 32'(16));
        go_idle();

        // STUDY: pitch 5 waits for its key; other keys are ignored
        rom[0] = 7'b101_10_00;
        bus.state  = STUDY;
        bus.key_in = 7'h6f;
        start_song(1);
        repeat (3) step();
        for (int i = 0; i < 100; i++) begin
            check($sformatf("study_hold_%0d", i), 32'(bus.note_led), 32'(8'h10));
            step();
        end
        bus.key_in = 7'h10;
        check("study_key_cycle", 32'(bus.note_led), 32'(8'h10));
        step();
        check("study_key_sampled", 32'(bus.note_led), 32'(8'h10));
        step();
        bus.key_in = 7'h00;
        check("study_gap1", 32'(sample_obs()), 32'(mk(8'h00, 8'h00, 7'd0, 1'b0, 1'b1)));
        step();
        check("study_gap2", 32'(sample_obs()), 32'(mk(8'h00, 8'h00, 7'd0, 1'b0, 1'b1)));
        step();
        check("study_isend", 32'(bus.isEnd), 32'(1));
        $display("study: key release of note checked");
        go_idle();

        // Empty song
        bus.state = CHAL;
        start_song(0);
        run_trace("empty_song", 1'b0);
        go_idle();

        // Start together with inactive state: abort wins
        bus.state = 3'b000;
        bus.start = 1'b1;
        bus.song_len = AW'(2);
        step();
        bus.start = 1'b0;
        bus.state = AUTO;
        step();
        step();
        check("abort_wins_busy", 32'(bus.busy), 32'(0));
        $display("abort_wins: start ignored");

        // Mid-PLAY abort via state 3'b100
        rom[0] = 7'b001_10_00;
        rom[1] = 7'b011_11_01;
        start_song(2);
        repeat (5) step();
        check("abort_in_play", 32'(bus.note_led), 32'(8'h01));
        bus.state = 3'b100;
        step();
        check("abort_outputs", 32'(sample_obs()), 32'(0));
        check("abort_rom_addr", 32'(bus.rom_addr), 32'(0));
        $display("abort: outputs cleared");

        // Asynchronous reset during GAP
        bus.state = AUTO;
        start_song(2);
        repeat (11) step();
        check("pre_reset_gap", 32'(sample_obs()), 32'(mk(8'h00, 8'h84, 7'd0, 1'b0, 1'b1)));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'(sample_obs()), 32'(0));
        check("async_reset_rom_addr", 32'(bus.rom_addr), 32'(0));
        step();
        rst = 1'b0;
        $display("async reset: outputs cleared between edges");

        // Random timed songs
        for (int s = 0; s < 6; s++) begin
            len  = int'($urandom_range(1, 5));
            mode = ($urandom_range(0, 1) == 0) ? AUTO : CHAL;
            for (int i = 0; i < len; i++) rom[i] = 7'($urandom_range(0, 127));
            go_idle();
            bus.state  = mode;
            bus.key_in = 7'($urandom_range(0, 127));
            start_song(len);
            run_trace($sformatf("rand%0d_len%0d", s, len), 1'b0);
        end

        // Restart while busy
        rom[0] = 7'($urandom_range(0, 127));
        rom[1] = 7'($urandom_range(0, 127));
        go_idle();
        bus.state = AUTO;
        start_song(2);
        repeat (6) step();
        start_song(2);
        run_trace("restart", 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
